// File: rtl/nn_train_ctrl.sv
// nn_train_ctrl: training sequencer for the 4-input / N-hidden perceptron datapath.
// Per sample it requests an input, runs the forward pass for FWD_LAT cycles, then
// strobes each hidden backprop unit once. It counts samples and epochs, and pulses
// done_o when training completes.
// Optional feature macro: TRAIN_ABORT_EN adds the abort_i input, which returns the
// sequencer to IDLE from any busy state.
module nn_train_ctrl #(
  parameter int N_HIDDEN  = 4,
  parameter int N_SAMPLES = 4,
  parameter int FWD_LAT   = 2,
  parameter int EPOCH_W   = 8,
  localparam int HID_W    = (N_HIDDEN  > 1) ? $clog2(N_HIDDEN)  : 1,
  localparam int SMP_W    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
  localparam int FWD_W    = (FWD_LAT   > 1) ? $clog2(FWD_LAT)   : 1
) (
  input  logic               clk_i,
  input  logic               rst,
  input  logic               start_i,
  input  logic [EPOCH_W-1:0] epochs_i,
  input  logic               sample_valid_i,
`ifdef TRAIN_ABORT_EN
  input  logic               abort_i,
`endif
  output logic               sample_ready_o,
  output logic               fwd_en_o,
  output logic               bp_en_o,
  output logic [HID_W-1:0]   hid_sel_o,
  output logic               zero_wt_rst_o,
  output logic [SMP_W-1:0]   sample_idx_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FWD   = 3'd3,
    ST_BP    = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [HID_W-1:0] HID_LAST = HID_W'(N_HIDDEN - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(N_SAMPLES - 1);
  localparam logic [FWD_W-1:0] FWD_INIT = FWD_W'(FWD_LAT - 1);

  state_t             state;
  logic [EPOCH_W-1:0] epochs_r;
  logic [FWD_W-1:0]   fwd_cnt;
  logic [EPOCH_W-1:0] epoch_nxt;
  logic               abort_req;

  // The next epoch value is compared before it is stored, so a full-scale
  // epoch request finishes without the counter ever wrapping.
  assign epoch_nxt = epoch_o + EPOCH_W'(1);

`ifdef TRAIN_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  // Sequencer FSM: strobes are computed for the state being entered, so every output is a flop.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state          <= ST_IDLE;
      epochs_r       <= '0;
      fwd_cnt        <= '0;
      sample_ready_o <= 1'b0;
      fwd_en_o       <= 1'b0;
      bp_en_o        <= 1'b0;
      hid_sel_o      <= '0;
      zero_wt_rst_o  <= 1'b0;
      sample_idx_o   <= '0;
      epoch_o        <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      // Strobes default low; each transition raises only what its target state needs.
      sample_ready_o <= 1'b0;
      fwd_en_o       <= 1'b0;
      bp_en_o        <= 1'b0;
      hid_sel_o      <= '0;
      zero_wt_rst_o  <= 1'b0;
      done_o         <= 1'b0;
      busy_o         <= 1'b1;
      if (abort_req && (state != ST_IDLE)) begin
        // Abort keeps sample/epoch counters so software can see where it stopped.
        state  <= ST_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              epochs_r     <= epochs_i;
              sample_idx_o <= '0;
              epoch_o      <= '0;
              if (epochs_i == '0) begin
                state  <= ST_DONE;
                done_o <= 1'b1;
                busy_o <= 1'b0;
              end else begin
                state         <= ST_CLEAR;
                zero_wt_rst_o <= 1'b1;
              end
            end else begin
              busy_o <= 1'b0;
            end
          end
          ST_CLEAR: begin
            state          <= ST_LOAD;
            sample_ready_o <= 1'b1;
          end
          ST_LOAD: begin
            if (sample_valid_i) begin
              state    <= ST_FWD;
              fwd_en_o <= 1'b1;
              fwd_cnt  <= FWD_INIT;
            end else begin
              sample_ready_o <= 1'b1;
            end
          end
          ST_FWD: begin
            if (fwd_cnt == '0) begin
              state   <= ST_BP;
              bp_en_o <= 1'b1;
            end else begin
              fwd_cnt  <= fwd_cnt - FWD_W'(1);
              fwd_en_o <= 1'b1;
            end
          end
          ST_BP: begin
            if (hid_sel_o == HID_LAST) begin
              state <= ST_NEXT;
            end else begin
              bp_en_o   <= 1'b1;
              hid_sel_o <= hid_sel_o + HID_W'(1);
            end
          end
          ST_NEXT: begin
            if (sample_idx_o == SMP_LAST) begin
              sample_idx_o <= '0;
              epoch_o      <= epoch_nxt;
              if (epoch_nxt == epochs_r) begin
                state  <= ST_DONE;
                done_o <= 1'b1;
                busy_o <= 1'b0;
              end else begin
                state          <= ST_LOAD;
                sample_ready_o <= 1'b1;
              end
            end else begin
              sample_idx_o   <= sample_idx_o + SMP_W'(1);
              state          <= ST_LOAD;
              sample_ready_o <= 1'b1;
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
